// File: rtl/underflow_event_queue_pkg.sv
// Shared types and constants for the underflow event queue.
package underflow_event_queue_pkg;

    localparam int CNT_W       = 4;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_EPOCH_W = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_e;

endpackage

// File: rtl/underflow_event_queue_if.sv
// Event handshake between the queue (master) and its consumer (slave).
interface underflow_event_queue_if
    import underflow_event_queue_pkg::*;
#(
    parameter int EPOCH_W = DEF_EPOCH_W
);
    logic               evt_valid;
    logic [EPOCH_W-1:0] evt_data;
    logic               evt_ready;

    modport master (output evt_valid, output evt_data, input evt_ready);
    modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/event_fifo.sv
// Power-of-two FIFO holding wrap epochs; a push while full is accepted only
// when a pop frees a slot on the same edge.
module event_fifo #(
    parameter int DEPTH   = 4,
    parameter int EPOCH_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [EPOCH_W-1:0] din,
    output logic [EPOCH_W-1:0] dout,
    output logic               full,
    output logic               empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [EPOCH_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [OCC_W-1:0]   occ;
    logic               do_pop;
    logic               do_push;

    assign empty   = (occ == '0);
    assign full    = (occ == OCC_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage write; contents are don't-care until pushed, dout is gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/underflow_event_queue.sv
// Watches an upstream 4-bit down counter, counts 0->15 wraps into an epoch
// and queues each new epoch as an event for a consumer.
//
//  state | meaning
//  IDLE  | no previous count sample held yet
//  TRACK | prev_cnt valid; wrap and sequence checks active
module underflow_event_queue
    import underflow_event_queue_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int EPOCH_W = DEF_EPOCH_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CNT_W-1:0]        count_in,
    input  logic                    flag_clr,
    output logic                    ovf,
    output logic                    seq_err,
    underflow_event_queue_if.master evt_if
);
    state_e             state;
    logic [CNT_W-1:0]   prev_cnt;
    logic [EPOCH_W-1:0] epoch;
    logic [EPOCH_W-1:0] epoch_nxt;
    logic               tracking;
    logic               wrap;
    logic               seq_bad;
    logic               drop;
    logic               full;
    logic               empty;

    assign tracking  = (state == TRACK);
    assign wrap      = tracking && (prev_cnt == '0) && (count_in == '1);
    assign seq_bad   = tracking && (count_in != prev_cnt - CNT_W'(1));
    assign epoch_nxt = epoch + EPOCH_W'(1);
    // Full only accepts a push when the consumer frees the head this edge.
    assign drop      = wrap && full && !evt_if.evt_ready;

    assign evt_if.evt_valid = !empty;

    // Sample tracking FSM and wrap epoch counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            prev_cnt <= '0;
            epoch    <= '0;
        end else begin
            state    <= TRACK;
            prev_cnt <= count_in;
            if (wrap) epoch <= epoch_nxt;
        end
    end

    // Sticky flags; a new set on the same edge outranks flag_clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf     <= 1'b0;
            seq_err <= 1'b0;
        end else begin
            ovf     <= (ovf && !flag_clr) || drop;
            seq_err <= (seq_err && !flag_clr) || seq_bad;
        end
    end

    event_fifo #(
        .DEPTH   (DEPTH),
        .EPOCH_W (EPOCH_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wrap),
        .pop   (evt_if.evt_ready),
        .din   (epoch_nxt),
        .dout  (evt_if.evt_data),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_underflow_event_queue.sv
// Bench for underflow_event_queue: an 8-bit epoch instance and a 4-bit epoch
// instance share count_in/reset/flag_clr and are compared every edge against
// a queue-based reference model, with directed scenarios on top.
module tb_underflow_event_queue;
    import underflow_event_queue_pkg::*;

    localparam int DEPTH = 4;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic [3:0] count_in = 4'd0;
    logic       flag_clr = 1'b0;
    logic       ovf_a, seq_a, ovf_b, seq_b;

    underflow_event_queue_if #(.EPOCH_W(8)) if_a ();
    underflow_event_queue_if #(.EPOCH_W(4)) if_b ();

    underflow_event_queue #(.DEPTH(DEPTH), .EPOCH_W(8)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .count_in (count_in),
        .flag_clr (flag_clr),
        .ovf      (ovf_a),
        .seq_err  (seq_a),
        .evt_if   (if_a)
    );

    underflow_event_queue #(.DEPTH(DEPTH), .EPOCH_W(4)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .count_in (count_in),
        .flag_clr (flag_clr),
        .ovf      (ovf_b),
        .seq_err  (seq_b),
        .evt_if   (if_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: upstream sample history, epochs, flags and event queues.
    bit          m_have;
    int          m_prev;
    int          m_epoch [2];
    bit          m_ovf   [2];
    bit          m_seq;
    int unsigned mq      [2][$];
    int          mmod    [2] = '{256, 16};
    int          cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_have = 1'b0;
        m_prev = 0;
        m_seq  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_epoch[k] = 0;
            m_ovf[k]   = 1'b0;
            mq[k].delete();
        end
    endtask

    task automatic model_edge(input int c, input bit ra, input bit rb, input bit cl);
        bit wr, er, dropped;
        bit rdy [2];
        rdy[0] = ra;
        rdy[1] = rb;
        wr = m_have && (m_prev == 0) && (c == 15);
        er = m_have && (c != (m_prev + 15) % 16);
        for (int k = 0; k < 2; k++) begin
            dropped = 1'b0;
            if (rdy[k] && mq[k].size() > 0) void'(mq[k].pop_front());
            if (wr) begin
                m_epoch[k] = (m_epoch[k] + 1) % mmod[k];
                if (mq[k].size() < DEPTH) mq[k].push_back(m_epoch[k]);
                else dropped = 1'b1;
            end
            m_ovf[k] = (m_ovf[k] && !cl) || dropped;
        end
        m_seq  = (m_seq && !cl) || er;
        m_prev = c;
        m_have = 1'b1;
    endtask

    task automatic check_all();
        chk("a_valid", if_a.evt_valid, mq[0].size() > 0);
        chk("a_data",  if_a.evt_data,  mq[0].size() > 0 ? mq[0][0] : 0);
        chk("a_ovf",   ovf_a, m_ovf[0]);
        chk("a_seq",   seq_a, m_seq);
        chk("b_valid", if_b.evt_valid, mq[1].size() > 0);
        chk("b_data",  if_b.evt_data,  mq[1].size() > 0 ? mq[1][0] : 0);
        chk("b_ovf",   ovf_b, m_ovf[1]);
        chk("b_seq",   seq_b, m_seq);
    endtask

    // One clock edge with the inputs as currently driven, then compare at edge+1.
    task automatic step();
        int c;
        bit ra, rb, cl, live;
        c    = count_in;
        ra   = if_a.evt_ready;
        rb   = if_b.evt_ready;
        cl   = flag_clr;
        @(posedge clk);
        live = reset;
        if (live) model_edge(c, ra, rb, cl);
        #1;
        check_all();
    endtask

    // Edge with the free-running upstream counter, which then decrements.
    task automatic step_cnt();
        count_in = 4'(cnt);
        step();
        cnt      = (cnt + 15) % 16;
        count_in = 4'(cnt);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step_cnt();
    endtask

    // Mid-cycle async reset: outputs must clear before any clock edge.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        model_reset();
        chk({tag, "_valid"}, if_a.evt_valid, 0);
        chk({tag, "_data"},  if_a.evt_data,  0);
        chk({tag, "_ovf"},   ovf_a, 0);
        chk({tag, "_seq"},   seq_a, 0);
        cnt      = 0;
        count_in = 4'd0;
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int pulses;
        if_a.evt_ready = 1'b0;
        if_b.evt_ready = 1'b0;
        model_reset();
        cnt = 0;
        #2;
        chk("rst_valid", if_a.evt_valid, 0);
        chk("rst_data",  if_a.evt_data,  0);
        chk("rst_ovf",   ovf_a, 0);
        chk("rst_seq",   seq_a, 0);
        reset = 1'b1;

        // Free-running counter, consumer always ready: one event per 16 edges.
        if_a.evt_ready = 1'b1;
        if_b.evt_ready = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step_cnt();
            if (if_a.evt_valid === 1'b1) begin
                pulses++;
                chk("run_data", if_a.evt_data, pulses);
            end
        end
        chk("run_pulses", pulses, 3);
        chk("run_ovf", ovf_a, 0);
        chk("run_seq", seq_a, 0);

        // Stalled consumer across 6 wraps, then drain in order.
        do_reset("r34");
        if_a.evt_ready = 1'b0;
        if_b.evt_ready = 1'b0;
        run(82);
        chk("stall_ovf", ovf_a, 1);
        if_a.evt_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("drain_data", if_a.evt_data, k);
            step_cnt();
        end
        chk("drain_empty", if_a.evt_valid, 0);
        run(12);
        chk("epoch7_valid", if_a.evt_valid, 1);
        chk("epoch7_data",  if_a.evt_data,  7);

        // Full queue with a pop on the same edge as the 5th wrap.
        do_reset("r35");
        if_a.evt_ready = 1'b0;
        if_b.evt_ready = 1'b0;
        run(65);
        chk("full_head", if_a.evt_data, 1);
        if_a.evt_ready = 1'b1;
        step_cnt();
        chk("pp_ovf",  ovf_a, 0);
        chk("pp_head", if_a.evt_data, 2);
        for (int k = 2; k <= 5; k++) begin
            chk("pp_drain", if_a.evt_data, k);
            step_cnt();
        end
        chk("pp_empty", if_a.evt_valid, 0);

        // Forced count sequence and flag_clr priority.
        if_b.evt_ready = 1'b1;
        flag_clr = 1'b0; count_in = 4'd5; step();
        flag_clr = 1'b1; count_in = 4'd4; step();
        chk("seq_clr", seq_a, 0);
        flag_clr = 1'b0; count_in = 4'd2; step();
        chk("seq_skip", seq_a, 1);
        flag_clr = 1'b1; count_in = 4'd1; step();
        chk("seq_clr2", seq_a, 0);
        flag_clr = 1'b1; count_in = 4'd5; step();
        chk("seq_set_wins", seq_a, 1);
        flag_clr = 1'b0;
        cnt = 4;
        count_in = 4'd4;

        // Randomized consumer, glitches and flag clears.
        for (int i = 0; i < 400; i++) begin
            if_a.evt_ready = 1'($urandom_range(0, 1));
            if_b.evt_ready = 1'($urandom_range(0, 1));
            flag_clr       = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 23) == 0) count_in = 4'($urandom_range(0, 15));
            else                            count_in = 4'(cnt);
            step();
            cnt      = (int'(count_in) + 15) % 16;
            count_in = 4'(cnt);
        end
        flag_clr = 1'b0;

        // Async reset with three events queued; epoch restarts at 1.
        do_reset("r37a");
        if_a.evt_ready = 1'b0;
        if_b.evt_ready = 1'b0;
        run(34);
        chk("r37_queued", if_a.evt_data, 1);
        #2;
        do_reset("r37");
        if_a.evt_ready = 1'b1;
        if_b.evt_ready = 1'b1;
        run(2);
        chk("r37_first_valid", if_a.evt_valid, 1);
        chk("r37_first_data",  if_a.evt_data,  1);

        // 4-bit epoch wrap-around on the second instance.
        do_reset("r38");
        run(2);
        for (int w = 1; w <= 17; w++) begin
            if (w > 1) run(16);
            if (w == 16) begin
                chk("ep16_valid", if_b.evt_valid, 1);
                chk("ep16_data",  if_b.evt_data,  0);
                chk("ep16_wide",  if_a.evt_data,  16);
            end
            if (w == 17) begin
                chk("ep17_data", if_b.evt_data, 1);
                chk("ep17_wide", if_a.evt_data, 17);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
